// File: rtl/video_scan_out.sv
// video_scan_out: raster scan-out engine. A pixel clock-enable derived from the
// system clock advances H/V counters, fetches source pixels over a request/valid
// handshake with power-of-two pixel replication, and drives pixel data,
// data-enable and syncs aligned one pixel period behind the counters.
// Optional feature: define VIDEO_UNDERRUN_COUNT_EN to add a saturating 16-bit
// underrunCount output.
module video_scan_out #(
  parameter int PIX_W       = 8,
  parameter int PIXEL_DIV   = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 1,
  parameter bit H_SYNC_POL  = 1'b0,
  parameter bit V_SYNC_POL  = 1'b0,
  parameter int ADDR_W      = 17
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memRead,
  input  logic [PIX_W-1:0]  memData,
  input  logic              memValid,
  output logic [PIX_W-1:0]  pixelOut,
  output logic              dataEnable,
  output logic              hSync,
  output logic              vSync,
  output logic              frameStart,
  output logic              underrun,
  input  logic              underrunClear
`ifdef VIDEO_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]       underrunCount
`endif
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW           = $clog2(H_TOTAL);
  localparam int VW           = $clog2(V_TOTAL);
  localparam int DW           = $clog2(PIXEL_DIV);
  localparam int SCALE_MASK   = (1 << SCALE_SHIFT) - 1;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_VISIBLE >> SCALE_SHIFT);

  logic [DW-1:0]     divCount;
  logic              tick;
  logic [HW-1:0]     hCount;
  logic [VW-1:0]     vCount;
  logic              hWrap;
  logic              vWrap;
  logic              visible;
  logic              fetchHit;
  logic              lineStep;
  logic              hActive;
  logic              vActive;
  logic [ADDR_W-1:0] lineBase;
  logic              pending;
  logic [PIX_W-1:0]  hold;
  logic [PIX_W-1:0]  nextHold;
  logic              captureHit;
  logic              underrunEvent;
  logic              visD;
  logic              hActD;
  logic              vActD;

  assign tick          = (divCount == DW'(PIXEL_DIV - 1));
  assign hWrap         = (hCount == HW'(H_TOTAL - 1));
  assign vWrap         = (vCount == VW'(V_TOTAL - 1));
  assign visible       = (hCount < HW'(H_VISIBLE)) && (vCount < VW'(V_VISIBLE));
  assign fetchHit      = visible && ((hCount & HW'(SCALE_MASK)) == '0);
  assign lineStep      = (vCount < VW'(V_VISIBLE)) &&
                         ((vCount & VW'(SCALE_MASK)) == VW'(SCALE_MASK));
  assign hActive       = (hCount >= HW'(H_SYNC_START)) && (hCount <= HW'(H_SYNC_END));
  assign vActive       = (vCount >= VW'(V_SYNC_START)) && (vCount <= VW'(V_SYNC_END));
  assign captureHit    = pending && memValid;
  assign nextHold      = captureHit ? memData : hold;
  assign underrunEvent = tick && pending && !memValid;

  // Pixel clock-enable divider: tick on the last system clock of each pixel
  always_ff @(posedge clock) begin
    if (reset)     divCount <= '0;
    else if (tick) divCount <= '0;
    else           divCount <= divCount + 1'b1;
  end

  // Raster position; vCount only moves when hCount wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (tick) begin
      if (hWrap) begin
        hCount <= '0;
        vCount <= vWrap ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  // Start address of the current source line, stepped once per replicated line group
  always_ff @(posedge clock) begin
    if (reset) begin
      lineBase <= '0;
    end else if (tick && hWrap) begin
      if (vWrap)         lineBase <= '0;
      else if (lineStep) lineBase <= lineBase + LINE_STEP;
    end
  end

  // Fetch stage: issue one request per source pixel and track whether it is outstanding
  always_ff @(posedge clock) begin
    if (reset) begin
      memAddress <= '0;
      memRead    <= 1'b0;
      pending    <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      memRead    <= 1'b0;
      frameStart <= 1'b0;
      if (captureHit) pending <= 1'b0;
      if (tick) begin
        frameStart <= (hCount == '0) && (vCount == '0);
        pending    <= fetchHit;
        if (fetchHit) begin
          memAddress <= lineBase + ADDR_W'(hCount >> SCALE_SHIFT);
          memRead    <= 1'b1;
        end
      end
    end
  end

  // Hold register keeps the last returned pixel for replication and underrun fill
  always_ff @(posedge clock) begin
    if (reset) hold <= '0;
    else       hold <= nextHold;
  end

  // Output stage: position flags delayed one pixel so syncs line up with pixel data
  always_ff @(posedge clock) begin
    if (reset) begin
      visD       <= 1'b0;
      hActD      <= 1'b0;
      vActD      <= 1'b0;
      dataEnable <= 1'b0;
      pixelOut   <= '0;
      hSync      <= ~H_SYNC_POL;
      vSync      <= ~V_SYNC_POL;
    end else if (tick) begin
      visD       <= visible;
      hActD      <= hActive;
      vActD      <= vActive;
      dataEnable <= visD;
      pixelOut   <= visD ? nextHold : '0;
      hSync      <= hActD ? H_SYNC_POL : ~H_SYNC_POL;
      vSync      <= vActD ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear
  always_ff @(posedge clock) begin
    if (reset)              underrun <= 1'b0;
    else if (underrunEvent) underrun <= 1'b1;
    else if (underrunClear) underrun <= 1'b0;
  end

`ifdef VIDEO_UNDERRUN_COUNT_EN
  // Saturating underrun event counter, cleared together with the flag
  always_ff @(posedge clock) begin
    if (reset) begin
      underrunCount <= '0;
    end else if (underrunEvent) begin
      if (underrunCount != 16'hFFFF) underrunCount <= underrunCount + 1'b1;
    end else if (underrunClear) begin
      underrunCount <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_video_scan_out.sv
// tb_video_scan_out: small-raster bench for video_scan_out with a randomized
// memory responder (random latency, dropped requests, stray valids) and a
// per-clock behavioural model of the raster, fetch addresses and pixel stream.
module tb_video_scan_out;

  localparam int PIX_W     = 8;
  localparam int PIXEL_DIV = 3;
  localparam int H_VIS     = 16;
  localparam int H_FR      = 2;
  localparam int H_SY      = 3;
  localparam int H_BK      = 3;
  localparam int V_VIS     = 8;
  localparam int V_FR      = 1;
  localparam int V_SY      = 2;
  localparam int V_BK      = 2;
  localparam int SS        = 1;
  localparam bit H_POL     = 1'b0;
  localparam bit V_POL     = 1'b1;
  localparam int ADDR_W    = 10;
  localparam int H_TOTAL   = H_VIS + H_FR + H_SY + H_BK;
  localparam int V_TOTAL   = V_VIS + V_FR + V_SY + V_BK;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] memAddress;
  logic              memRead;
  logic [PIX_W-1:0]  memData = '0;
  logic              memValid = 1'b0;
  logic [PIX_W-1:0]  pixelOut;
  logic              dataEnable;
  logic              hSync;
  logic              vSync;
  logic              frameStart;
  logic              underrun;
  logic              underrunClear = 1'b0;
`ifdef VIDEO_UNDERRUN_COUNT_EN
  logic [15:0]       underrunCount;
`endif

  logic [7:0] mem [1024];
  bit         dropEnable = 1'b0;
  bit         lastAnswered = 1'b1;
  int         checks = 0;
  int         fails = 0;

  video_scan_out #(
    .PIX_W(PIX_W), .PIXEL_DIV(PIXEL_DIV),
    .H_VISIBLE(H_VIS), .H_FRONT(H_FR), .H_SYNC(H_SY), .H_BACK(H_BK),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FR), .V_SYNC(V_SY), .V_BACK(V_BK),
    .SCALE_SHIFT(SS), .H_SYNC_POL(H_POL), .V_SYNC_POL(V_POL), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .memAddress(memAddress),
    .memRead(memRead),
    .memData(memData),
    .memValid(memValid),
    .pixelOut(pixelOut),
    .dataEnable(dataEnable),
    .hSync(hSync),
    .vSync(vSync),
    .frameStart(frameStart),
    .underrun(underrun),
    .underrunClear(underrunClear)
`ifdef VIDEO_UNDERRUN_COUNT_EN
    ,
    .underrunCount(underrunCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit clr, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #3;
      reset = rst;
      underrunClear = clr;
    end
  endtask

  // Memory: answers each request 0..PIXEL_DIV-1 clocks after seeing memRead,
  // optionally drops requests, and injects stray valids when nothing is outstanding
  initial begin : memResponder
    bit                slotActive;
    int                slotWait;
    logic [ADDR_W-1:0] slotAddr;
    int                sinceRead;
    int                k;
    slotActive = 1'b0;
    slotWait   = 0;
    slotAddr   = '0;
    sinceRead  = 100;
    forever begin
      @(posedge clock);
      #1;
      memValid = 1'b0;
      memData  = 8'($urandom);
      sinceRead++;
      if (slotActive) begin
        if (slotWait == 0) begin
          memValid   = 1'b1;
          memData    = mem[slotAddr];
          slotActive = 1'b0;
        end else begin
          slotWait--;
        end
      end
      if (memRead === 1'b1) begin
        sinceRead = 0;
        k = $urandom_range(0, PIXEL_DIV - 1);
        if (dropEnable && memAddress != '0 && $urandom_range(0, 99) < 8) begin
          lastAnswered = 1'b0;
        end else begin
          lastAnswered = 1'b1;
          if (k == 0) begin
            memValid = 1'b1;
            memData  = mem[memAddress];
          end else begin
            slotActive = 1'b1;
            slotWait   = k - 1;
            slotAddr   = memAddress;
          end
        end
      end else if (!slotActive && !memValid && sinceRead >= PIXEL_DIV &&
                   $urandom_range(0, 9) == 0) begin
        memValid = 1'b1;
        memData  = 8'($urandom);
      end
    end
  end

  // Reference model: raster position from tick count, addresses from line/column
  // arithmetic, displayed pixel from the last answered fetch; checks every clock
  initial begin : compareProc
    bit        rstIn, clrIn, tickNow, evt;
    int        divc, tickCount, h, v;
    bit        prevValid, prevVis, prevH, prevV, prevFetch, prevAns;
    int        prevAddr;
    logic [7:0] held;
    int        expRead, expAddr, expFS, expDE, expPix, expHS, expVS, expUnder, expCount;
    divc = 0; tickCount = 0; prevValid = 0; prevVis = 0; prevH = 0; prevV = 0;
    prevFetch = 0; prevAns = 1; prevAddr = 0; held = '0;
    expRead = 0; expAddr = 0; expFS = 0; expDE = 0; expPix = 0;
    expHS = int'(!H_POL); expVS = int'(!V_POL); expUnder = 0; expCount = 0;
    forever begin
      @(negedge clock);
      rstIn = reset;
      clrIn = underrunClear;
      @(posedge clock);
      #2;
      if (rstIn) begin
        divc = 0; tickCount = 0; prevValid = 0; held = '0;
        expRead = 0; expAddr = 0; expFS = 0; expDE = 0; expPix = 0;
        expHS = int'(!H_POL); expVS = int'(!V_POL); expUnder = 0; expCount = 0;
      end else begin
        tickNow = (divc == PIXEL_DIV - 1);
        divc    = tickNow ? 0 : divc + 1;
        expRead = 0;
        expFS   = 0;
        evt     = 0;
        if (tickNow) begin
          if (prevValid) begin
            if (prevFetch) begin
              if (prevAns) held = mem[prevAddr];
              else         evt  = 1;
            end
            expDE  = int'(prevVis);
            expPix = prevVis ? int'(held) : 0;
            expHS  = prevH ? int'(H_POL) : int'(!H_POL);
            expVS  = prevV ? int'(V_POL) : int'(!V_POL);
          end
          h = tickCount % H_TOTAL;
          v = (tickCount / H_TOTAL) % V_TOTAL;
          prevVis   = (h < H_VIS) && (v < V_VIS);
          prevH     = (h >= H_VIS + H_FR) && (h < H_VIS + H_FR + H_SY);
          prevV     = (v >= V_VIS + V_FR) && (v < V_VIS + V_FR + V_SY);
          prevFetch = prevVis && (h % (1 << SS) == 0);
          if (prevFetch) begin
            expRead  = 1;
            expAddr  = (v >> SS) * (H_VIS >> SS) + (h >> SS);
            prevAddr = expAddr;
            prevAns  = lastAnswered;
          end
          expFS     = int'(h == 0 && v == 0);
          prevValid = 1;
          tickCount++;
        end
        if (evt) begin
          expUnder = 1;
          if (expCount < 65535) expCount++;
        end else if (clrIn) begin
          expUnder = 0;
          expCount = 0;
        end
      end
      checkOutput("memRead",    int'(memRead),    expRead);
      checkOutput("memAddress", int'(memAddress), expAddr);
      checkOutput("frameStart", int'(frameStart), expFS);
      checkOutput("dataEnable", int'(dataEnable), expDE);
      checkOutput("pixelOut",   int'(pixelOut),   expPix);
      checkOutput("hSync",      int'(hSync),      expHS);
      checkOutput("vSync",      int'(vSync),      expVS);
      checkOutput("underrun",   int'(underrun),   expUnder);
`ifdef VIDEO_UNDERRUN_COUNT_EN
      checkOutput("underrunCount", int'(underrunCount), expCount);
`endif
    end
  end

  initial begin : mainStimulus
    int n, period, reads, hsClocks, vsClocks, pixCount;
    int pix [12];
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a) ^ 8'h5A;
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 1);

    // Literal frame measurements with a well-behaved memory
    n = 0;
    do begin
      @(posedge clock);
      #3;
      n++;
    end while (!frameStart && n < 2000);
    checkOutput("firstFrameStartSeen", int'(frameStart), 1);
    period = 0; reads = 0; hsClocks = 0; vsClocks = 0; pixCount = 0;
    for (int i = 0; i < 12; i++) pix[i] = -1;
    do begin
      @(posedge clock);
      #3;
      period++;
      if (memRead) reads++;
      if (!hSync) hsClocks++;
      if (vSync) vsClocks++;
      if (dataEnable && pixCount < 12) begin
        pix[pixCount] = int'(pixelOut);
        pixCount++;
      end
    end while (!frameStart && period < 3000);
    checkOutput("framePeriodClocks", period, 936);
    checkOutput("readsPerFrame", reads, 64);
    checkOutput("hSyncActiveClocks", hsClocks, 117);
    checkOutput("vSyncActiveClocks", vsClocks, 144);
    checkOutput("line0Pixel0", pix[0], 8'h5A);
    checkOutput("line0Pixel1", pix[3], 8'h5A);
    checkOutput("line0Pixel2", pix[6], 8'h5B);
    checkOutput("line0Pixel3", pix[9], 8'h5B);

    // Randomized phase: dropped requests, random clears, one mid-frame reset
    dropEnable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c == 1700) begin
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
        applyStimulus(1'b1, 1'b0, 2);
      end
      applyStimulus(1'b0, ($urandom_range(0, 24) == 0), 1);
    end
    dropEnable = 1'b0;
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
